// File: rtl/coin_acceptor.sv
// Coin-slot front end: sync, debounce, edge detect, queue and
// paced emission of 2-bit coin codes for the vending FSM.
module coin_acceptor #(
    parameter int DEBOUNCE = 4,
    parameter int GAP      = 2,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coin5_raw,
    input  logic                       coin10_raw,
    input  logic                       enable,
    output logic [1:0]                 coin_code,
    output logic                       coin_valid,
    output logic                       reject,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP
    } state_e;

    logic [1:0]          sync5_q, sync10_q;
    logic [1:0]          synced;
    logic [1:0]          lvl_q, lvl_d;
    logic [1:0]          prev_q;
    logic [1:0][DW-1:0]  cnt_q, cnt_d;
    logic [1:0]          rise;

    logic [1:0]          mem_q [DEPTH];
    logic [PW-1:0]       wr_q, wr_d;
    logic [PW-1:0]       rd_q, rd_d;
    logic [CW-1:0]       count_q, count_d;
    logic                push, pop;
    logic [1:0]          push_code;

    state_e              state_q, state_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [1:0]          code_q, code_d;
    logic                valid_q, valid_d;
    logic                rej_q, rej_d;
    logic                ovf_q, ovf_d;

    // bit 0 is the 5 rs channel, bit 1 the 10 rs channel
    assign synced = {sync10_q[1], sync5_q[1]};
    assign rise   = lvl_q & ~prev_q;

    // per-channel debounce: flip only after DEBOUNCE differing cycles
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        for (int c = 0; c < 2; c++) begin
            if (synced[c] != lvl_q[c]) begin
                if (cnt_q[c] == DW'(DEBOUNCE - 1)) begin
                    lvl_d[c] = ~lvl_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
        end
    end

    // synchronizers, debounced levels and edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync5_q  <= '0;
            sync10_q <= '0;
            lvl_q    <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
        end else begin
            sync5_q  <= {sync5_q[0], coin5_raw};
            sync10_q <= {sync10_q[0], coin10_raw};
            lvl_q    <= lvl_d;
            prev_q   <= lvl_q;
            cnt_q    <= cnt_d;
        end
    end

    // emitter: pop in IDLE, one EMIT cycle, then GAP idle cycles
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        code_d  = 2'b00;
        valid_d = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    code_d  = mem_q[rd_q];
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                state_d = S_GAP;
                gap_d   = GW'(GAP - 1);
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // classify a coin event: both at once, disabled, full, or queued
    always_comb begin
        push      = 1'b0;
        rej_d     = 1'b0;
        ovf_d     = ovf_q;
        push_code = rise[0] ? 2'b01 : 2'b10;
        if (rise != 2'b00) begin
            if (rise == 2'b11) begin
                rej_d = 1'b1;
            end else if (!enable) begin
                rej_d = 1'b1;
            end else if (count_q == CW'(DEPTH) && !pop) begin
                rej_d = 1'b1;
                ovf_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
    end

    // fifo pointer and occupancy update
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // fifo storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
        end else if (push) begin
            mem_q[wr_q] <= push_code;
        end
    end

    // fifo pointers, emitter state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            gap_q   <= '0;
            code_q  <= 2'b00;
            valid_q <= 1'b0;
            rej_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            state_q <= state_d;
            gap_q   <= gap_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            rej_q   <= rej_d;
            ovf_q   <= ovf_d;
        end
    end

    assign coin_code  = code_q;
    assign coin_valid = valid_q;
    assign reject     = rej_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage for the vending machine FSM. Takes the two raw, bouncy, asynchronous coin-slot sensors (5 rs and 10 rs) and turns them into clean coin codes on the FSM's 2-bit coin input. It synchronizes and debounces each sensor, detects coin insertions, and queues them in a small FIFO. Each queued coin is emitted as a single-cycle code, followed by an enforced idle gap so the downstream FSM always sees `00` between coins.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive stable cycles (after sync) needed to change a debounced level; must be ≥ 1.
- `GAP`, default 2: idle cycles (code `00`) forced after every emitted coin; must be ≥ 1.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `coin5_raw`  in  1  raw 5 rs sensor, asynchronous, active-high.
- `coin10_raw`  in  1  raw 10 rs sensor, asynchronous, active-high.
- `enable`  in  1  1 = accept coins; 0 = every detected coin is rejected.
- `coin_code`  out  2  coin code to the FSM: 00 none, 01 = 5 rs, 10 = 10 rs; 11 is never driven.
- `coin_valid`  out  1  high exactly when `coin_code` ≠ 00.
- `reject`  out  1  one-cycle pulse; the detected coin was not queued (return it to the user).
- `overflow`  out  1  sticky; a coin was rejected because the FIFO was full. Cleared only by reset.
- `fifo_count`  out  $clog2(DEPTH+1)  number of queued coins.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer, reset value 0.
- **Debounce (per channel):**
  - The counter counts while the synced value differs from the debounced level.
  - It clears to 0 whenever they are equal.
  - When the count reaches `DEBOUNCE`, the debounced level flips and the counter clears.
- **Event:** a rising edge of a debounced level (previous 0, current 1) is a coin event. Falling edges are ignored.
- **Classification, in the event cycle, by priority:**
  1. Both channels rise in the same cycle: `reject` = 1, nothing queued.
  2. `enable` = 0: `reject` = 1, nothing queued.
  3. FIFO full and no pop this cycle: `reject` = 1, `overflow` set, nothing queued.
  4. Otherwise: push code 01 or 10 into the FIFO.
- **FIFO:** circular buffer, pointers wrap modulo `DEPTH`.
  - Push and pop in the same cycle are both honoured, including when full (count unchanged).
  - Pop on empty never occurs.
- **Emitter FSM, states IDLE / EMIT / GAP:**
  - IDLE: if `fifo_count` > 0, pop the head, load it into the `coin_code` register, go to EMIT. Otherwise stay.
  - EMIT (1 cycle): `coin_code` holds the entry and `coin_valid` = 1. Next state is GAP, and the gap counter loads `GAP`−1.
  - GAP: `coin_code` = 00. Decrement the counter; when it reaches 0, go to IDLE.
  - Result: the minimum spacing between consecutive codes is `GAP`+2 cycles (EMIT + `GAP` + IDLE pop cycle).
- **Outputs:** all outputs are registered.

## Timing
- **Reset values:**
  - Outputs: `coin_code` = 00, `coin_valid` = 0, `reject` = 0, `overflow` = 0, `fifo_count` = 0.
  - Internal: FSM in IDLE; synchronizers, debounced levels and counters all 0.
- **Latency:** with the FIFO empty and the emitter in IDLE, `coin_valid` rises `DEBOUNCE`+4 rising edges after the first edge that samples the raw input high. With `DEBOUNCE` = 4 that is 8 edges.
  - 2 edges: synchronizer.
  - `DEBOUNCE` edges: debounce.
  - 1 edge: event → push.
  - 1 edge: IDLE pop → EMIT.
- **`reject` timing:** asserted on the edge after the event cycle, exactly one cycle wide.
- **Glitch rejection:** bounce shorter than `DEBOUNCE` consecutive synced cycles produces no event.
- **Holding the sensor:** a raw input held high indefinitely yields exactly one coin. A new coin requires the debounced level to return to 0 first.
- **Reset mid-operation:** `rst_n` low empties the FIFO, returns the FSM to IDLE, and forces `coin_code` to 00 immediately (asynchronous), even mid-EMIT.
- **Release:** the FSM's first possible action is on the first rising edge with `rst_n` high.
- **`enable`:** sampled only in the event cycle. Coins already queued are still emitted when `enable` = 0.

## Test plan
1. **Single coin:** `DEBOUNCE` = 4. Hold `coin5_raw` high for 20 cycles → `coin_code` = 01 for exactly one cycle at edge 8; no further codes; `fifo_count` returns to 0.
2. **Bounce:** toggle `coin10_raw` high/low every 2 cycles for 12 cycles, then hold high → exactly one 10 code. The 2-cycle pulses alone produce nothing.
3. **Burst and ordering:** `GAP` = 2. Insert 5, 10, 5, 10 rs, 6 cycles apart → codes 01, 10, 01, 10 in that order. Each code is separated by ≥ 3 cycles of 00. `fifo_count` peaks and then drains to 0.
4. **Overflow:** `DEPTH` = 4. Insert 6 coins faster than the drain rate → at least one `reject` pulse, `overflow` = 1 and stays 1. Accepted coins are emitted in order.
5. **Simultaneous and disabled coins:** both raws rise together → `reject` pulse, no code. `enable` = 0 with one 5 rs coin → `reject`, no code, `overflow` stays 0.
6. **Reset during EMIT:** assert `rst_n` = 0 while `coin_valid` = 1 with 2 coins queued → `coin_code` = 00 and `fifo_count` = 0 immediately. After release, no code is emitted without new coins.
